// File: rtl/action_decoder.sv
// action_decoder: turns the raw keyboard keycode into one-hot player action
// levels. Attacks fire on a press edge only. They are held for a number of
// video frames and followed by a cooldown lockout, so a held key cannot
// repeat an attack.
module action_decoder #(
  parameter int unsigned ACT_FRAMES  = 8,
  parameter int unsigned COOL_FRAMES = 4,
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07,
  parameter logic [7:0]  KEY_STAND   = 8'h16,
  parameter logic [7:0]  KEY_KICK    = 8'h0D,
  parameter logic [7:0]  KEY_FIGHT   = 8'h0E,
  parameter logic [7:0]  KEY_JUMP    = 8'h1A,
  parameter logic [7:0]  KEY_DODGE   = 8'h07 + 8'h02
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic       left,
  output logic       right,
  output logic       stand,
  output logic       kick,
  output logic       fight,
  output logic       jump,
  output logic       dodge,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MOVE, ACTION, COOLDOWN} state_t;

  // Counters hold "frames remaining minus one", so expiry is detected at zero.
  localparam logic [7:0] ACT_LOAD  = 8'(ACT_FRAMES - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOL_FRAMES - 1);

  // Output vector bit order: {dodge, jump, fight, kick, stand, right, left}
  localparam logic [6:0] OH_LEFT  = 7'b0000001;
  localparam logic [6:0] OH_RIGHT = 7'b0000010;
  localparam logic [6:0] OH_STAND = 7'b0000100;
  localparam logic [6:0] OH_KICK  = 7'b0001000;
  localparam logic [6:0] OH_FIGHT = 7'b0010000;
  localparam logic [6:0] OH_JUMP  = 7'b0100000;
  localparam logic [6:0] OH_DODGE = 7'b1000000;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] prev_key_q;
  logic [6:0] out_q, out_d;
  logic [6:0] atk;
  logic       press_edge;
  logic       eval_idle;

  // Maps an attack keycode to its one-hot output; zero for non-attack codes.
  function automatic logic [6:0] attack_decode(input logic [7:0] k);
    attack_decode = '0;
    if (k == KEY_KICK)       attack_decode = OH_KICK;
    else if (k == KEY_FIGHT) attack_decode = OH_FIGHT;
    else if (k == KEY_JUMP)  attack_decode = OH_JUMP;
    else if (k == KEY_DODGE) attack_decode = OH_DODGE;
  endfunction

  // Next-state, counter and output decision for the current cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    eval_idle  = 1'b0;
    atk        = attack_decode(keycode);
    press_edge = (keycode != prev_key_q) && (atk != 7'd0);

    case (state_q)
      IDLE, MOVE: eval_idle = 1'b1;
      ACTION: begin
        if (frame_tick) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = COOL_LOAD;
            out_d   = OH_STAND;
          end
        end
      end
      COOLDOWN: begin
        out_d = OH_STAND;
        if (frame_tick) begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else               eval_idle = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = OH_STAND;
      end
    endcase

    // Idle-style evaluation; a tick on this cycle is not counted against
    // a freshly started attack because cnt is simply loaded.
    if (eval_idle) begin
      if (press_edge) begin
        state_d = ACTION;
        cnt_d   = ACT_LOAD;
        out_d   = atk;
      end else if (keycode == KEY_LEFT) begin
        state_d = MOVE;
        out_d   = OH_LEFT;
      end else if (keycode == KEY_RIGHT) begin
        state_d = MOVE;
        out_d   = OH_RIGHT;
      end else begin
        state_d = IDLE;
        out_d   = OH_STAND;
      end
    end
  end

  // State, counter, previous key and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      prev_key_q <= 8'h00;
      out_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_key_q <= keycode;
      out_q      <= out_d;
    end
  end

  assign {dodge, jump, fight, kick, stand, right, left} = out_q;
  assign busy = (state_q == ACTION) || (state_q == COOLDOWN);

endmodule

// File: tb/tb_action_decoder.sv
// Testbench for action_decoder: directed scenarios plus randomized traffic
// checked against a frame-counting behavioural model.
module tb_action_decoder;

  localparam int ACT  = 8;
  localparam int COOL = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       left, right, stand, kick, fight, jump, dodge, busy;
  logic [6:0] act_vec;

  int tests = 0;
  int fails = 0;

  action_decoder #(.ACT_FRAMES(ACT), .COOL_FRAMES(COOL)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick),
    .left(left), .right(right), .stand(stand), .kick(kick), .fight(fight),
    .jump(jump), .dodge(dodge), .busy(busy)
  );

  always #5 Clk = ~Clk;

  assign act_vec = {dodge, jump, fight, kick, stand, right, left};

  // ---------------- reference model ----------------
  // Action index: 0 left, 1 right, 2 stand, 3 kick, 4 fight, 5 jump, 6 dodge
  logic [7:0] key_tab [7] = '{8'h04, 8'h07, 8'h16, 8'h0D, 8'h0E, 8'h1A, 8'h09};
  int         m_mode;       // 0 free, 1 attacking, 2 cooling
  int         m_ticks_left; // frame ticks still to be seen in this phase
  logic [7:0] m_prev;
  logic [6:0] m_out;
  logic       m_busy;

  task automatic model_choose(input logic [7:0] k);
    int idx;
    idx = -1;
    for (int i = 0; i < 7; i++) if (key_tab[i] == k) idx = i;
    if (idx >= 3 && k != m_prev) begin
      m_mode = 1; m_ticks_left = ACT; m_out = 7'(1 << idx);
    end else if (idx == 0 || idx == 1) begin
      m_mode = 0; m_out = 7'(1 << idx);
    end else begin
      m_mode = 0; m_out = 7'b0000100;
    end
  endtask

  task automatic model_step(input logic [7:0] k, input logic t, input logic r);
    if (!r) begin
      m_mode = 0; m_ticks_left = 0; m_prev = 8'h00; m_out = 7'd0;
    end else begin
      if (m_mode == 1) begin
        if (t) begin
          m_ticks_left--;
          if (m_ticks_left == 0) begin
            m_mode = 2; m_ticks_left = COOL; m_out = 7'b0000100;
          end
        end
      end else if (m_mode == 2) begin
        if (t) begin
          m_ticks_left--;
          if (m_ticks_left == 0) model_choose(k);
        end
      end else begin
        model_choose(k);
      end
      m_prev = k;
    end
    m_busy = (m_mode != 0);
  endtask

  // Drive one cycle of inputs and advance the model at the same edge.
  task automatic drive(input logic [7:0] k, input logic t, input logic r);
    @(negedge Clk);
    keycode = k; frame_tick = t; Reset = r;
    @(posedge Clk);
    model_step(k, t, r);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      drive(8'h00, 1'b0, 1'b0);
      tests++;
      if (act_vec !== 7'd0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset c%0d: act=%b busy=%b, expected act=0000000 busy=0", c, act_vec, busy);
      end
    end
    for (int c = 0; c < 5; c++) begin
      drive(8'h00, 1'b0, 1'b1);
      tests++;
      if (act_vec !== 7'b0000100 || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_stand c%0d: act=%b busy=%b, expected act=0000100 busy=0", c, act_vec, busy);
      end
    end
  endtask

  task automatic test_move;
    logic [7:0] seq [5]    = '{8'h04, 8'h04, 8'h04, 8'h07, 8'h00};
    logic [6:0] expv [5]   = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000010, 7'b0000100};
    for (int c = 0; c < 5; c++) begin
      drive(seq[c], 1'b0, 1'b1);
      tests++;
      if (act_vec !== expv[c] || busy !== 1'b0 || act_vec !== m_out) begin
        fails++;
        $display("FAIL move c%0d: act=%b busy=%b, expected act=%b busy=0", c, act_vec, busy, expv[c]);
      end
    end
  endtask

  task automatic test_kick_hold;
    int kick_cyc, busy_cyc, rises;
    logic kick_prev;
    kick_cyc = 0; busy_cyc = 0; rises = 0; kick_prev = 1'b0;
    for (int c = 0; c < 4 * 40; c++) begin
      drive(8'h0D, (c % 4) == 3, 1'b1);
      tests++;
      if (act_vec !== m_out || busy !== m_busy) begin
        fails++;
        $display("FAIL kick_hold c%0d: act=%b busy=%b, expected act=%b busy=%b", c, act_vec, busy, m_out, m_busy);
      end
      if (kick) kick_cyc++;
      if (busy) busy_cyc++;
      if (kick && !kick_prev) rises++;
      kick_prev = kick;
    end
    tests++;
    if (kick_cyc != 31 || busy_cyc != 47 || rises != 1) begin
      fails++;
      $display("FAIL kick_width: kick_cycles=%0d busy_cycles=%0d rises=%0d, expected 31 47 1", kick_cyc, busy_cyc, rises);
    end
    tests++;
    if (act_vec !== 7'b0000100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL kick_held_refire: act=%b busy=%b, expected act=0000100 busy=0", act_vec, busy);
    end
  endtask

  task automatic test_ignore;
    int jump_cyc, kick_cyc;
    jump_cyc = 0; kick_cyc = 0;
    drive(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 80; c++) begin
      logic [7:0] k;
      k = (c < 6) ? 8'h0D : (c < 12) ? 8'h04 : (c < 18) ? 8'h1A : 8'h00;
      drive(k, (c % 4) == 3, 1'b1);
      tests++;
      if (act_vec !== m_out || busy !== m_busy) begin
        fails++;
        $display("FAIL ignore c%0d: act=%b busy=%b, expected act=%b busy=%b", c, act_vec, busy, m_out, m_busy);
      end
      if (jump) jump_cyc++;
      if (kick) kick_cyc++;
    end
    tests++;
    if (jump_cyc != 0 || kick_cyc != 31) begin
      fails++;
      $display("FAIL ignore_summary: jump_cycles=%0d kick_cycles=%0d, expected 0 31", jump_cyc, kick_cyc);
    end
  endtask

  task automatic test_coincident;
    int jump_cyc;
    jump_cyc = 0;
    drive(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      drive(8'h1A, (c % 2) == 0, 1'b1);
      tests++;
      if (act_vec !== m_out || busy !== m_busy) begin
        fails++;
        $display("FAIL coincident c%0d: act=%b busy=%b, expected act=%b busy=%b", c, act_vec, busy, m_out, m_busy);
      end
      if (jump) jump_cyc++;
    end
    tests++;
    if (jump_cyc != 16) begin
      fails++;
      $display("FAIL coincident_width: jump_cycles=%0d, expected 16", jump_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int ticks;
    ticks = 0;
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h0E, 1'b0, 1'b1);
    tests++;
    if (act_vec !== 7'b0010000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL fight_start: act=%b busy=%b, expected act=0010000 busy=1", act_vec, busy);
    end
    while (ticks < 3) begin
      drive(8'h0E, 1'b1, 1'b1);
      ticks++;
    end
    drive(8'h0E, 1'b0, 1'b0);
    tests++;
    if (act_vec !== 7'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_clear: act=%b busy=%b, expected act=0000000 busy=0", act_vec, busy);
    end
    drive(8'h0E, 1'b0, 1'b1);
    tests++;
    if (act_vec !== 7'b0010000 || busy !== 1'b1 || act_vec !== m_out) begin
      fails++;
      $display("FAIL reset_mid_refire: act=%b busy=%b, expected act=0010000 busy=1", act_vec, busy);
    end
  endtask

  task automatic test_random;
    logic [7:0] pool [9] = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h0D, 8'h0E, 8'h1A, 8'h09, 8'h55};
    logic [7:0] k;
    k = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        k = pool[$urandom_range(8)];
        if (k == 8'h55) k = 8'($urandom);
      end
      drive(k, $urandom_range(2) == 0, $urandom_range(99) != 0);
      tests++;
      if (act_vec !== m_out || busy !== m_busy || ($countones(act_vec) > 1)) begin
        fails++;
        $display("FAIL random c%0d key=%h: act=%b busy=%b, expected act=%b busy=%b", c, k, act_vec, busy, m_out, m_busy);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
    m_mode = 0; m_ticks_left = 0; m_prev = 8'h00; m_out = 7'd0; m_busy = 1'b0;
    test_reset;
    test_move;
    test_kick_hold;
    test_ignore;
    test_coincident;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/action_decoder.md
# action_decoder

Converts the raw 8-bit keyboard keycode into the one-hot player action levels (left, right, stand, kick, fight, jump, dodge) consumed by the stick-figure facing/stand state machine. It sits directly upstream of that state machine, between the keyboard interface and the player logic. Attack moves are edge-triggered and timed in video frames, with a lockout and cooldown, so a held key cannot spam attacks.

## Interface
- ACT_FRAMES, default 8: frames an attack action stays asserted (legal range 1-255).
- COOL_FRAMES, default 4: post-attack lockout in frames (legal range 1-255).
- KEY_LEFT 8'h04, KEY_RIGHT 8'h07, KEY_STAND 8'h16, KEY_KICK 8'h0D, KEY_FIGHT 8'h0E, KEY_JUMP 8'h1A, KEY_DODGE 8'h07+8'h02 (8'h09): USB HID keycodes.
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  **one clock; reset is synchronous and active-low** (Reset=0 resets on the next Clk edge).
- keycode  in  8  current key from the keyboard interface; 8'h00 means no key.
- frame_tick  in  1  one-Clk pulse per video frame.
- left, right, stand, kick, fight, jump, dodge  out  1 each  registered action levels; at most one high.
- busy  out  1  high in ACTION and COOLDOWN.

## Operation
- Registers: state {IDLE, MOVE, ACTION, COOLDOWN}, 8-bit frame counter cnt, 8-bit prev_key, and output flops.
- prev_key <= keycode every cycle in every state. A press edge is keycode != prev_key with keycode being an attack code (kick, fight, jump, dodge).
- IDLE: stand=1.
  - Attack press edge: go to ACTION, raise the matching output, load cnt=ACT_FRAMES-1.
  - Otherwise KEY_LEFT or KEY_RIGHT: go to MOVE with left or right=1.
  - KEY_STAND, 8'h00, or an unrecognised code: stay in IDLE with stand=1.
- MOVE: left or right follows keycode each cycle.
  - Attack press edge: go to ACTION, same as IDLE.
  - Any other non-movement code: go to IDLE with stand=1.
  - Switching directly between left and right stays in MOVE and swaps the output.
- ACTION: the attack output is held and all keycodes are ignored.
  - On frame_tick with cnt!=0: cnt decrements.
  - On frame_tick with cnt==0: go to COOLDOWN, load cnt=COOL_FRAMES-1, stand=1, attack output drops.
- COOLDOWN: stand=1 and keycodes are ignored.
  - On frame_tick with cnt!=0: cnt decrements.
  - On frame_tick with cnt==0: go to IDLE. That cycle's keycode is evaluated as in IDLE, except that an attack key still held equals prev_key and does not fire.
- Priority within a cycle: Reset, then state logic. A frame_tick that coincides with the press edge is not counted.
- Outputs are one-hot or all-zero only during reset. stand is never high together with another output.
- cnt saturation is impossible: both loads are at most 254 and only decrement at nonzero values.

## Timing
- Reset value of every output: all action outputs 0, busy 0. Also state=IDLE, cnt=0, prev_key=8'h00.
- First cycle after Reset deasserts: stand=1.
- Decode latency is one Clk: a keycode sampled at edge N appears on the outputs after edge N.
- Attack width is exactly ACT_FRAMES frame_ticks. The output falls on the edge that samples the ACT_FRAMES-th tick after entry.
- Cooldown is exactly COOL_FRAMES ticks. busy covers ACTION plus COOLDOWN and falls on the same edge the state returns to IDLE.
- Reset asserted mid-ACTION clears everything at the next edge. prev_key=0 after reset, so a held attack key fires once reset releases.

## Test plan
- Reset then keycode=8'h00 for 5 cycles -> all outputs 0 during reset, then stand=1, busy=0.
- keycode=8'h04 for 3 cycles, then 8'h07, then 8'h00 -> left=1 one cycle after the first sample, right=1 one cycle after the switch, then stand=1.
- keycode=8'h0D held for 40 frames with ACT_FRAMES=8, COOL_FRAMES=4 -> kick=1 for exactly 8 ticks, stand=1 with busy=1 for 4 ticks, then stand=1 with busy=0 and no second kick while held.
- Kick in progress, then keycode=8'h04 and 8'h1A pressed -> ignored. kick still ends on tick 8 and jump never asserts.
- Press 8'h1A on the same cycle as frame_tick -> jump lasts 8 full ticks after that cycle, and the coincident tick is not counted.
- Reset=0 at tick 3 of a fight with 8'h0E still held -> all outputs 0, then IDLE, then fight re-fires on the first post-reset evaluation.
